// File: rtl/pattern_window_counter_if.sv
// rtl/pattern_window_counter_if.sv - Pulse input, window control and result handshake bundle.
interface pattern_window_counter_if #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
);
  logic             y_in;
  logic             enable;
  logic [WIN_W-1:0] win_len;
  logic             out_ready;
  logic             clr_ovr;
  logic [CNT_W-1:0] count_out;
  logic             out_valid;
  logic             overrun;
  logic             busy;

  modport master (
    output y_in, enable, win_len, out_ready, clr_ovr,
    input  count_out, out_valid, overrun, busy
  );

  modport slave (
    input  y_in, enable, win_len, out_ready, clr_ovr,
    output count_out, out_valid, overrun, busy
  );
endinterface

// File: rtl/pattern_window_counter.sv
// rtl/pattern_window_counter.sv - Counts detector pulses over back-to-back windows of L cycles.
module pattern_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input logic                     clk,
  input logic                     reset,
  pattern_window_counter_if.slave bus
);
  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       COUNT    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  logic [0:0]       state, state_nxt;
  logic [WIN_W-1:0] timer, len;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             last;
  logic             transfer;
  logic             drop;

  assign cnt_inc  = (bus.y_in && cnt != CNT_MAX) ? cnt + CNT_ONE : cnt;
  assign last     = (state == COUNT) && (timer == len - WIN_ONE);
  assign transfer = bus.out_valid && bus.out_ready;
  assign drop     = last && bus.out_valid && !bus.out_ready;

  // Enable alone steers the FSM; a final cycle with enable high rolls straight into the next window.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable)  state_nxt = COUNT;
      COUNT:   if (!bus.enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      timer         <= '0;
      len           <= '0;
      cnt           <= '0;
      bus.count_out <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.busy <= (state_nxt == COUNT);

      if (state == COUNT && !last && bus.enable) begin
        timer <= timer + WIN_ONE;
        cnt   <= cnt_inc;
      end else begin
        timer <= '0;
        cnt   <= '0;
        if (bus.enable) len <= (bus.win_len == '0) ? WIN_ONE : bus.win_len;
      end

      // A pending, unaccepted result wins over a newly completed one.
      if (last && !drop) begin
        bus.count_out <= cnt_inc;
        bus.out_valid <= 1'b1;
      end else if (transfer) begin
        bus.out_valid <= 1'b0;
      end

      if (drop)             bus.overrun <= 1'b1;
      else if (bus.clr_ovr) bus.overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pattern_window_counter.sv
// tb/tb_pattern_window_counter.sv - Directed bench for pattern_window_counter.
module tb_pattern_window_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  pattern_window_counter_if #(.CNT_W(8), .WIN_W(8)) bus ();
  pattern_window_counter_if #(.CNT_W(2), .WIN_W(8)) bus2 ();

  pattern_window_counter #(.CNT_W(8), .WIN_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  pattern_window_counter #(.CNT_W(2), .WIN_W(8)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [7:0] wl, input logic y, input logic rdy);
    bus.enable = en; bus.win_len = wl; bus.y_in = y; bus.out_ready = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 8'd3, 1'b1, 1'b0);
    bus.clr_ovr = 1'b0;
    tick(); tick();
    total++; if (bus.count_out !== 8'd0) $display("FAIL reset_count got %0d want 0", bus.count_out); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got %0b want 0", bus.overrun); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else passed++;
    reset = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_basic_window();
    drive(1'b1, 8'd4, 1'b0, 1'b1);
    tick();
    total++; if (bus.busy !== 1'b1) $display("FAIL basic_busy got %0b want 1", bus.busy); else passed++;
    bus.y_in = 1'b1; tick();
    bus.y_in = 1'b0; tick(); tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", bus.out_valid); else passed++;
    bus.y_in = 1'b1; tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %0b want 1", bus.out_valid); else passed++;
    total++; if (bus.count_out !== 8'd2) $display("FAIL basic_count got %0d want 2", bus.count_out); else passed++;
    bus.y_in = 1'b0; tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_valid_drop got %0b want 0", bus.out_valid); else passed++;
    bus.enable = 1'b0; tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL basic_idle_busy got %0b want 0", bus.busy); else passed++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'd0, 1'b1, 1'b1);
    tick(); tick();
    total++; if (bus.out_valid !== 1'b1 || bus.count_out !== 8'd1) $display("FAIL b2b_first got v=%0b c=%0d want v=1 c=1", bus.out_valid, bus.count_out); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.count_out !== 8'd1) $display("FAIL b2b_second got v=%0b c=%0d want v=1 c=1", bus.out_valid, bus.count_out); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy got %0b want 1", bus.busy); else passed++;
    bus.enable = 1'b0; tick();
    total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b1) $display("FAIL b2b_last got busy=%0b v=%0b want busy=0 v=1", bus.busy, bus.out_valid); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.overrun !== 1'b0) $display("FAIL b2b_overrun got %0b want 0", bus.overrun); else passed++;
  endtask

  task automatic test_long_window();
    drive(1'b1, 8'd255, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 254; i++) tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL long_early_valid got %0b want 0", bus.out_valid); else passed++;
    bus.enable = 1'b0; tick();
    total++; if (bus.count_out !== 8'd255 || bus.out_valid !== 1'b1) $display("FAIL long_count got c=%0d v=%0b want c=255 v=1", bus.count_out, bus.out_valid); else passed++;
    tick();
  endtask

  task automatic test_saturate();
    bus2.enable = 1'b1; bus2.win_len = 8'd6; bus2.y_in = 1'b1; bus2.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    bus2.enable = 1'b0; tick();
    total++; if (bus2.count_out !== 2'd3 || bus2.out_valid !== 1'b1) $display("FAIL sat_count got c=%0d v=%0b want c=3 v=1", bus2.count_out, bus2.out_valid); else passed++;
    tick();
  endtask

  task automatic test_overrun();
    logic [4:0] ya = 5'b00111;
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b1, 8'd5, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin bus.y_in = ya[i]; tick(); end
    total++; if (bus.count_out !== 8'd3 || bus.out_valid !== 1'b1) $display("FAIL ovr_first got c=%0d v=%0b want c=3 v=1", bus.count_out, bus.out_valid); else passed++;
    bus.y_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.enable = 1'b0; bus.clr_ovr = 1'b1; tick();
    total++; if (bus.count_out !== 8'd3) $display("FAIL ovr_kept got %0d want 3", bus.count_out); else passed++;
    total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set_wins got %0b want 1", bus.overrun); else passed++;
    bus.y_in = 1'b0; tick();
    total++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clear got %0b want 0", bus.overrun); else passed++;
    total++; if (bus.out_valid !== 1'b1 || bus.count_out !== 8'd3) $display("FAIL ovr_stable got c=%0d v=%0b want c=3 v=1", bus.count_out, bus.out_valid); else passed++;
    bus.clr_ovr = 1'b0;
  endtask

  task automatic test_replace_on_transfer();
    drive(1'b1, 8'd7, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) tick();
    total++; if (bus.count_out !== 8'd3) $display("FAIL repl_hold got %0d want 3", bus.count_out); else passed++;
    bus.out_ready = 1'b1; bus.enable = 1'b0; tick();
    total++; if (bus.count_out !== 8'd7 || bus.out_valid !== 1'b1) $display("FAIL repl_new got c=%0d v=%0b want c=7 v=1", bus.count_out, bus.out_valid); else passed++;
    total++; if (bus.overrun !== 1'b0) $display("FAIL repl_overrun got %0b want 0", bus.overrun); else passed++;
    bus.y_in = 1'b0; tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL repl_drain got %0b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_abort();
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b1, 8'd4, 1'b1, 1'b1);
    tick(); tick();
    bus.enable = 1'b0; tick();
    total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL abort_drop got busy=%0b v=%0b want 0 0", bus.busy, bus.out_valid); else passed++;
    for (int i = 0; i < 5; i++) tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL abort_no_result got %0b want 0", bus.out_valid); else passed++;
    bus.enable = 1'b1; bus.win_len = 8'd2; tick(); tick();
    reset = 1'b1; tick();
    total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.count_out !== 8'd0 || bus.overrun !== 1'b0)
      $display("FAIL abort_reset got busy=%0b v=%0b c=%0d o=%0b want all 0", bus.busy, bus.out_valid, bus.count_out, bus.overrun); else passed++;
    reset = 1'b0; bus.enable = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    total++; if (bus.out_valid !== 1'b0 || bus.count_out !== 8'd0) $display("FAIL abort_quiet got v=%0b c=%0d want 0 0", bus.out_valid, bus.count_out); else passed++;
  endtask

  initial begin
    bus.clr_ovr = 1'b0;
    bus2.enable = 1'b0; bus2.win_len = 8'd0; bus2.y_in = 1'b0; bus2.out_ready = 1'b0; bus2.clr_ovr = 1'b0;
    test_reset();
    test_basic_window();
    test_back_to_back();
    test_long_window();
    test_saturate();
    test_overrun();
    test_replace_on_transfer();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
